// File: rtl/rx_demodulate.sv
// 64-QAM hard-decision demapper for 52-subcarrier OFDM symbols: pilot check,
// per-axis slicing, point FIFO and a serializer that streams 6 bits per point.
module rx_demodulate #(
   parameter int FIFO_DEPTH = 64,
   parameter int N_SC       = 52
) (
   input  logic        clk_Modulation,
   input  logic        reset_n,
   input  logic        rx_demod_in_valid,
   input  logic [31:0] rx_demod_re_in,
   input  logic [31:0] rx_demod_im_in,
   input  logic        rx_demod_in_last,
   input  logic        rx_demod_out_ready,
   output logic        rx_demod_out_valid,
   output logic        rx_demod_out_bit,
   output logic        rx_demod_out_last,
   output logic        rx_pilot_vld,
   output logic        rx_pilot_polarity,
   output logic        rx_pilot_err,
   output logic [15:0] rx_n_ofdm_syms,
   output logic        rx_demod_overflow
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [5:0]    K_LAST   = 6'(N_SC - 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   // Decision thresholds 2, 4, 6 / sqrt(42) in Q2.30
   localparam logic signed [31:0] T1 = 32'sd331363920;
   localparam logic signed [31:0] T2 = 32'sd662727840;
   localparam logic signed [31:0] T3 = 32'sd994091760;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   function automatic logic [2:0] demap_axis(input logic signed [31:0] x);
      if (x < -T3)      return 3'b000;
      else if (x < -T2) return 3'b001;
      else if (x < -T1) return 3'b011;
      else if (x < 0)   return 3'b010;
      else if (x < T1)  return 3'b110;
      else if (x < T2)  return 3'b111;
      else if (x < T3)  return 3'b101;
      else              return 3'b100;
   endfunction

   logic signed [31:0] re_s, im_s;
   logic               acc, k_last, is_pilot;
   logic [5:0]         k_q;
   logic [15:0]        sym_cnt_q, n_syms_q;
   logic [3:0]         pil_q;
   logic               pilot_vld_q, pol_q, perr_q;

   assign re_s     = signed'(rx_demod_re_in);
   assign im_s     = signed'(rx_demod_im_in);
   assign acc      = rx_demod_in_valid;
   assign k_last   = (k_q == K_LAST);
   assign is_pilot = (k_q == 6'd5) || (k_q == 6'd19) || (k_q == 6'd32) || (k_q == 6'd46);

   // Sample stage: subcarrier index, pilot signs, symbol count
   always_ff @(posedge clk_Modulation or negedge reset_n) begin
      if (!reset_n) begin
         k_q         <= '0;
         sym_cnt_q   <= '0;
         n_syms_q    <= '0;
         pil_q       <= '0;
         pilot_vld_q <= 1'b0;
         pol_q       <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         pilot_vld_q <= acc && k_last;
         if (acc) begin
            k_q <= k_last ? 6'd0 : k_q + 6'd1;
            case (k_q)
               6'd5:    pil_q[0] <= ~re_s[31];
               6'd19:   pil_q[1] <= ~re_s[31];
               6'd32:   pil_q[2] <= ~re_s[31];
               6'd46:   pil_q[3] <= ~re_s[31];
               default: ;
            endcase
            if (k_last) begin
               pol_q  <= pil_q[0];
               perr_q <= !((pil_q == 4'b0111) || (pil_q == 4'b1000));
               if (rx_demod_in_last) begin
                  n_syms_q  <= sym_cnt_q + 16'd1;
                  sym_cnt_q <= '0;
               end else begin
                  sym_cnt_q <= sym_cnt_q + 16'd1;
               end
            end
         end
      end
   end

   // Point stage: sliced 6-bit point registered one cycle after acceptance
   logic       vld_p0, last_p0;
   logic [5:0] pt_p0;

   always_ff @(posedge clk_Modulation or negedge reset_n) begin
      if (!reset_n) vld_p0 <= 1'b0;
      else          vld_p0 <= acc && !is_pilot;
   end

   always_ff @(posedge clk_Modulation) begin
      pt_p0   <= {demap_axis(re_s), demap_axis(im_s)};
      last_p0 <= k_last && rx_demod_in_last;
   end

   // Point FIFO; a pop in the same cycle frees the slot for a write when full
   logic [6:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          wr_en, rd_en, fifo_empty, ovf_q;
   logic [6:0]    rd_data;

   assign wr_en      = vld_p0 && ((cnt_q != CNT_FULL) || rd_en);
   assign fifo_empty = (cnt_q == '0);
   assign rd_data    = mem_q[rd_ptr_q];

   always_ff @(posedge clk_Modulation) begin
      if (wr_en) mem_q[wr_ptr_q] <= {last_p0, pt_p0};
   end

   always_ff @(posedge clk_Modulation or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
         if (vld_p0 && !wr_en) ovf_q <= 1'b1;
      end
   end

   // Serializer: MSB-first shift of one popped entry
   state_t     state_q, state_d;
   logic [5:0] sh_q, sh_d;
   logic [2:0] idx_q, idx_d;
   logic       elast_q, elast_d, ovld_q, ovld_d;

   always_ff @(posedge clk_Modulation or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         elast_q <= 1'b0;
         ovld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         idx_q   <= idx_d;
         elast_q <= elast_d;
         ovld_q  <= ovld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      idx_d   = idx_q;
      elast_d = elast_q;
      ovld_d  = ovld_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = LOAD;
         end
         LOAD: begin
            rd_en   = 1'b1;
            sh_d    = rd_data[5:0];
            elast_d = rd_data[6];
            idx_d   = 3'd5;
            ovld_d  = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (ovld_q && rx_demod_out_ready) begin
               if (idx_q == 3'd0) begin
                  ovld_d  = 1'b0;
                  state_d = fifo_empty ? IDLE : LOAD;
               end else begin
                  idx_d = idx_q - 3'd1;
                  sh_d  = {sh_q[4:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_demod_out_valid = ovld_q;
   assign rx_demod_out_bit   = sh_q[5];
   assign rx_demod_out_last  = ovld_q && elast_q && (idx_q == 3'd0);
   assign rx_pilot_vld       = pilot_vld_q;
   assign rx_pilot_polarity  = pol_q;
   assign rx_pilot_err       = perr_q;
   assign rx_n_ofdm_syms     = n_syms_q;
   assign rx_demod_overflow  = ovf_q;

endmodule
